// File: rtl/net_load_ctrl_pkg.sv
// Shared network-loader definitions: packet layout, opcode enum and loader state enum.
package net_load_ctrl_pkg;

    localparam int mask_length_gp = 8;
    localparam int rs_imm_size_gp = 6;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        BAR   = 3'd3,
        PC    = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [4:0]  reserved;
        logic [9:0]  net_id;
        net_op_e     net_op;
        logic [15:0] net_addr;
        logic [31:0] net_data;
    } net_packet_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } net_load_state_e;

    function automatic logic op_is_legal(input net_op_e op);
        return (op == INSTR) || (op == REG) || (op == BAR) || (op == PC);
    endfunction

endpackage

// File: rtl/net_load_fifo.sv
// Synchronous FIFO, combinational head read; push is honoured when full only if a pop
// happens in the same cycle, otherwise it is ignored (caller flags the drop).
module net_load_fifo #(
    parameter int DEPTH_P = 4,
    parameter int WIDTH_P = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH_P-1:0] din,
    input  logic               pop,
    output logic [WIDTH_P-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH_P);

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH_P));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/net_load_ctrl.sv
// Network loader: packets for ID_P are queued, then applied one per cycle as registered strobes
// (two edges after arrival); an INSTR head stalls while imem_ready_i=0. Echo: NET_LOAD_ECHO_EN.
module net_load_ctrl
    import net_load_ctrl_pkg::*;
#(
    parameter logic [9:0] ID_P         = 10'd1,
    parameter int         FIFO_DEPTH_P = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  net_packet_s               net_packet_i,
    input  logic                      imem_ready_i,
    output logic                      imem_wen_o,
    output logic [9:0]                imem_addr_o,
    output logic [15:0]               imem_data_o,
    output logic                      rf_wen_o,
    output logic [rs_imm_size_gp-1:0] rf_addr_o,
    output logic [31:0]               rf_data_o,
    output logic                      bar_wen_o,
    output logic [mask_length_gp-1:0] bar_mask_o,
    output logic                      pc_wen_o,
    output logic [9:0]                pc_o,
    output logic                      core_run_o,
    output logic                      overflow_o,
    output logic                      bad_op_o,
    output logic [10:0]               instr_count_o,
    output net_packet_s               net_packet_o
);

    net_packet_s     head;
    net_load_state_e state;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic            unused_head;

    assign accept = reset && (net_packet_i.net_op != NULL) && (net_packet_i.net_id == ID_P);
    assign pop    = !fifo_empty && ((head.net_op != INSTR) || imem_ready_i);

    // Fields that no write port consumes.
    assign unused_head = ^{head.reserved, head.net_id, head.net_addr[15:10]};

    net_load_fifo #(
        .DEPTH_P (FIFO_DEPTH_P),
        .WIDTH_P ($bits(net_packet_s))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (net_packet_i),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            imem_wen_o    <= 1'b0;
            imem_addr_o   <= '0;
            imem_data_o   <= '0;
            rf_wen_o      <= 1'b0;
            rf_addr_o     <= '0;
            rf_data_o     <= '0;
            bar_wen_o     <= 1'b0;
            bar_mask_o    <= '0;
            pc_wen_o      <= 1'b0;
            pc_o          <= '0;
            core_run_o    <= 1'b0;
            overflow_o    <= 1'b0;
            bad_op_o      <= 1'b0;
            instr_count_o <= '0;
        end else begin
            imem_wen_o <= 1'b0;
            rf_wen_o   <= 1'b0;
            bar_wen_o  <= 1'b0;
            pc_wen_o   <= 1'b0;
            if (accept && fifo_full && !pop) begin
                overflow_o <= 1'b1;
            end
            if (pop) begin
                case (head.net_op)
                    INSTR: begin
                        imem_wen_o  <= 1'b1;
                        imem_addr_o <= head.net_addr[9:0];
                        imem_data_o <= head.net_data[15:0];
                        if (instr_count_o != 11'h7FF) begin
                            instr_count_o <= instr_count_o + 11'd1;
                        end
                        state      <= LOAD;
                        core_run_o <= 1'b0;
                    end
                    REG: begin
                        rf_wen_o   <= 1'b1;
                        rf_addr_o  <= head.net_addr[rs_imm_size_gp-1:0];
                        rf_data_o  <= head.net_data;
                        state      <= LOAD;
                        core_run_o <= 1'b0;
                    end
                    BAR: begin
                        bar_wen_o  <= 1'b1;
                        bar_mask_o <= head.net_data[mask_length_gp-1:0];
                        // A barrier update while running leaves the core running.
                        if (state == IDLE) begin
                            state <= LOAD;
                        end
                    end
                    PC: begin
                        pc_wen_o   <= 1'b1;
                        pc_o       <= head.net_data[9:0];
                        state      <= RUN;
                        core_run_o <= 1'b1;
                    end
                    default: begin
                        bad_op_o <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef NET_LOAD_ECHO_EN
    net_packet_s echo_pkt;
    logic        echo_vld;

    // Echo lags the strobe by one cycle, so the applied packet is staged first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            echo_vld     <= 1'b0;
            echo_pkt     <= '0;
            net_packet_o <= '0;
        end else begin
            echo_vld     <= pop && op_is_legal(head.net_op);
            echo_pkt     <= head;
            net_packet_o <= echo_vld ? echo_pkt : '0;
        end
    end
`else
    assign net_packet_o = '0;
`endif

endmodule

// File: tb/tb_net_load_ctrl.sv
// Self-checking bench for net_load_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_net_load_ctrl;
    import net_load_ctrl_pkg::*;

    localparam logic [9:0] ID    = 10'd1;
    localparam int         DEPTH = 4;
    localparam int OW = 1 + 10 + 16 + 1 + rs_imm_size_gp + 32 + 1 + mask_length_gp + 1 + 10
                        + 1 + 1 + 1 + 11 + $bits(net_packet_s);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic imem_ready = 1'b0;
    net_packet_s pkt_in = '0;

    logic                      imem_wen, rf_wen, bar_wen, pc_wen;
    logic [9:0]                imem_addr, pc;
    logic [15:0]               imem_data;
    logic [rs_imm_size_gp-1:0] rf_addr;
    logic [31:0]               rf_data;
    logic [mask_length_gp-1:0] bar_mask;
    logic                      core_run, overflow, bad_op;
    logic [10:0]               instr_count;
    net_packet_s               pkt_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    net_load_ctrl #(.ID_P(ID), .FIFO_DEPTH_P(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .net_packet_i  (pkt_in),
        .imem_ready_i  (imem_ready),
        .imem_wen_o    (imem_wen),
        .imem_addr_o   (imem_addr),
        .imem_data_o   (imem_data),
        .rf_wen_o      (rf_wen),
        .rf_addr_o     (rf_addr),
        .rf_data_o     (rf_data),
        .bar_wen_o     (bar_wen),
        .bar_mask_o    (bar_mask),
        .pc_wen_o      (pc_wen),
        .pc_o          (pc),
        .core_run_o    (core_run),
        .overflow_o    (overflow),
        .bad_op_o      (bad_op),
        .instr_count_o (instr_count),
        .net_packet_o  (pkt_out)
    );

    // Reference model: a queue of accepted packets, applied by the documented rules.
    net_packet_s               mq[$];
    net_packet_s               m_pend[$];
    logic                      m_imem_wen = 0, m_rf_wen = 0, m_bar_wen = 0, m_pc_wen = 0;
    logic [9:0]                m_imem_addr = 0, m_pc = 0;
    logic [15:0]               m_imem_data = 0;
    logic [rs_imm_size_gp-1:0] m_rf_addr = 0;
    logic [31:0]               m_rf_data = 0;
    logic [mask_length_gp-1:0] m_bar_mask = 0;
    logic                      m_ovf = 0, m_bad = 0;
    logic [10:0]               m_cnt = 0;
    net_packet_s               m_echo = '0;
    bit                        m_running = 0, m_started = 0;
    net_load_state_e           m_state;

    assign m_state = m_running ? RUN : (m_started ? LOAD : IDLE);

    logic [OW-1:0] obs, expv;
    logic          any_strobe;
    assign obs = {imem_wen, imem_addr, imem_data, rf_wen, rf_addr, rf_data, bar_wen, bar_mask,
                  pc_wen, pc, core_run, overflow, bad_op, instr_count, pkt_out};
    assign expv = {m_imem_wen, m_imem_addr, m_imem_data, m_rf_wen, m_rf_addr, m_rf_data, m_bar_wen,
                   m_bar_mask, m_pc_wen, m_pc, m_running, m_ovf, m_bad, m_cnt, m_echo};
    assign any_strobe = imem_wen | rf_wen | bar_wen | pc_wen;

    always @(posedge clk) begin : model
        net_packet_s p;
        bit legal;
        m_imem_wen = 0; m_rf_wen = 0; m_bar_wen = 0; m_pc_wen = 0; m_echo = '0;
        if (!reset) begin
            mq.delete(); m_pend.delete();
            m_imem_addr = 0; m_imem_data = 0; m_rf_addr = 0; m_rf_data = 0;
            m_bar_mask = 0; m_pc = 0; m_ovf = 0; m_bad = 0; m_cnt = 0;
            m_running = 0; m_started = 0;
        end else begin
`ifdef NET_LOAD_ECHO_EN
            if (m_pend.size() != 0) m_echo = m_pend.pop_front();
`endif
            if (mq.size() != 0 && (mq[0].net_op != INSTR || imem_ready)) begin
                p = mq.pop_front();
                legal = 1;
                case (p.net_op)
                    INSTR: begin
                        m_imem_wen = 1; m_imem_addr = p.net_addr[9:0]; m_imem_data = p.net_data[15:0];
                        if (m_cnt != 11'h7FF) m_cnt = m_cnt + 11'd1;
                        m_running = 0; m_started = 1;
                    end
                    REG: begin
                        m_rf_wen = 1; m_rf_addr = p.net_addr[rs_imm_size_gp-1:0]; m_rf_data = p.net_data;
                        m_running = 0; m_started = 1;
                    end
                    BAR: begin
                        m_bar_wen = 1; m_bar_mask = p.net_data[mask_length_gp-1:0]; m_started = 1;
                    end
                    PC: begin
                        m_pc_wen = 1; m_pc = p.net_data[9:0]; m_running = 1; m_started = 1;
                    end
                    default: begin m_bad = 1; legal = 0; end
                endcase
`ifdef NET_LOAD_ECHO_EN
                if (legal) m_pend.push_back(p);
`endif
            end
            if (pkt_in.net_op != NULL && pkt_in.net_id == ID) begin
                if (mq.size() < DEPTH) mq.push_back(pkt_in);
                else m_ovf = 1;
            end
        end
    end

    function automatic net_packet_s mk(input net_op_e op, input logic [9:0] id,
                                       input logic [15:0] a, input logic [31:0] d);
        net_packet_s p;
        p.reserved = 5'($urandom);
        p.net_id   = id;
        p.net_op   = op;
        p.net_addr = a;
        p.net_data = d;
        return p;
    endfunction

    task automatic do_reset();
        reset = 0; pkt_in = '0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; imem_ready = 1;
        pkt_in = mk(INSTR, ID, 16'd1, 32'd1);
        repeat (3) @(negedge clk);
        pkt_in = '0;
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_no_accept: got %h want 0", obs); end
    endtask

    task automatic test_instr();
        imem_ready = 1;
        pkt_in = mk(INSTR, ID, 16'd5, 32'hBEEFA5C3);
        @(negedge clk); pkt_in = '0;
        checks++; if (imem_wen !== 1'b0) begin errors++; $display("FAIL instr_early: got %b want 0", imem_wen); end
        @(negedge clk);
        checks++; if ({imem_wen, imem_addr, imem_data} !== {1'b1, 10'd5, 16'hA5C3})
            begin errors++; $display("FAIL instr_write: got %b/%h/%h want 1/005/a5c3", imem_wen, imem_addr, imem_data); end
        checks++; if (instr_count !== 11'd1) begin errors++; $display("FAIL instr_count: got %0d want 1", instr_count); end
        checks++; if (dut.state !== LOAD) begin errors++; $display("FAIL instr_state: got %0d want %0d", dut.state, LOAD); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL instr_model: got %h want %h", obs, expv); end
        @(negedge clk);
        checks++; if (imem_wen !== 1'b0) begin errors++; $display("FAIL instr_one_cycle: got %b want 0", imem_wen); end
    endtask

    task automatic test_reg_bar_pc();
        pkt_in = mk(REG, ID, 16'h003F, 32'hDEADBEEF);
        @(negedge clk);
        pkt_in = mk(BAR, ID, 16'h0000, 32'h2);
        @(negedge clk);
        checks++; if ({rf_wen, rf_addr, rf_data, bar_wen, pc_wen, core_run} !== {1'b1, 6'h3F, 32'hDEADBEEF, 3'b000})
            begin errors++; $display("FAIL reg_write: got %b/%h/%h bar=%b pc=%b run=%b", rf_wen, rf_addr, rf_data, bar_wen, pc_wen, core_run); end
        pkt_in = mk(PC, ID, 16'h0000, 32'h5);
        @(negedge clk); pkt_in = '0;
        checks++; if ({bar_wen, bar_mask, rf_wen, pc_wen} !== {1'b1, 8'h02, 2'b00})
            begin errors++; $display("FAIL bar_write: got %b/%h rf=%b pc=%b want 1/02/0/0", bar_wen, bar_mask, rf_wen, pc_wen); end
        @(negedge clk);
        checks++; if ({pc_wen, pc, core_run} !== {1'b1, 10'd5, 1'b1})
            begin errors++; $display("FAIL pc_write: got %b/%h run=%b want 1/005/1", pc_wen, pc, core_run); end
        @(negedge clk);
        checks++; if ({pc_wen, core_run} !== 2'b01 || dut.state !== RUN)
            begin errors++; $display("FAIL run_hold: got pc_wen=%b run=%b state=%0d want 0/1/%0d", pc_wen, core_run, dut.state, RUN); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL rbp_model: got %h want %h", obs, expv); end
    endtask

    task automatic test_run_exit();
        pkt_in = mk(INSTR, ID, 16'd7, 32'h1234);
        @(negedge clk); pkt_in = '0;
        checks++; if ({core_run, imem_wen} !== 2'b10)
            begin errors++; $display("FAIL run_before_exit: got run=%b wen=%b want 1/0", core_run, imem_wen); end
        @(negedge clk);
        checks++; if ({core_run, imem_wen} !== 2'b01 || dut.state !== LOAD)
            begin errors++; $display("FAIL run_exit: got run=%b wen=%b state=%0d want 0/1/%0d", core_run, imem_wen, dut.state, LOAD); end
    endtask

    task automatic test_overflow();
        imem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            pkt_in = mk(INSTR, ID, 16'(32 + i), 32'(16'h1000 + i));
            @(negedge clk);
        end
        pkt_in = '0;
        checks++; if ({overflow, imem_wen} !== 2'b10)
            begin errors++; $display("FAIL ovf_flag: got ovf=%b wen=%b want 1/0", overflow, imem_wen); end
        imem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({imem_wen, imem_addr, imem_data} !== {1'b1, 10'(32 + i), 16'(16'h1000 + i)})
                begin errors++; $display("FAIL ovf_order%0d: got %b/%h/%h want 1/%h", i, imem_wen, imem_addr, imem_data, 10'(32 + i)); end
        end
        @(negedge clk);
        checks++; if (imem_wen !== 1'b0 || instr_count !== 11'd6)
            begin errors++; $display("FAIL ovf_drained: got wen=%b cnt=%0d want 0/6", imem_wen, instr_count); end
    endtask

    task automatic test_reset_mid();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            pkt_in = mk(INSTR, ID, 16'(64 + i), 32'h77);
            @(negedge clk);
        end
        reset = 0;
        pkt_in = mk(REG, ID, 16'h1, 32'h1);
        @(negedge clk);
        reset = 1; pkt_in = '0; imem_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (any_strobe !== 1'b0 || obs !== '0)
                begin errors++; $display("FAIL reset_mid%0d: got %h want 0", i, obs); end
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_mid_state: got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_filter();
        do_reset(); imem_ready = 1;
        pkt_in = mk(INSTR, 10'd2, 16'd9, 32'h9);
        @(negedge clk); pkt_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({any_strobe, bad_op, instr_count} !== 13'd0)
                begin errors++; $display("FAIL wrong_id%0d: got strobe=%b bad=%b cnt=%0d want 0/0/0", i, any_strobe, bad_op, instr_count); end
        end
        pkt_in = mk(net_op_e'(3'd6), ID, 16'd9, 32'h9);
        @(negedge clk); pkt_in = '0;
        checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL bad_op_early: got %b want 0", bad_op); end
        @(negedge clk);
        checks++; if ({bad_op, any_strobe} !== 2'b10)
            begin errors++; $display("FAIL bad_op_set: got bad=%b strobe=%b want 1/0", bad_op, any_strobe); end
        @(negedge clk);
        checks++; if ({bad_op, any_strobe, pkt_out} !== {2'b10, 66'd0})
            begin errors++; $display("FAIL bad_op_after: got bad=%b strobe=%b echo=%h", bad_op, any_strobe, pkt_out); end
    endtask

    task automatic test_full_swap();
        do_reset(); imem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            pkt_in = mk(INSTR, ID, 16'(40 + i), 32'(i));
            @(negedge clk);
        end
        imem_ready = 1;
        pkt_in = mk(INSTR, ID, 16'd44, 32'd4);
        @(negedge clk); pkt_in = '0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({imem_wen, imem_addr} !== {1'b1, 10'(40 + i)})
                begin errors++; $display("FAIL full_swap%0d: got %b/%h want 1/%h", i, imem_wen, imem_addr, 10'(40 + i)); end
            @(negedge clk);
        end
        checks++; if ({overflow, imem_wen} !== 2'b00)
            begin errors++; $display("FAIL full_swap_ovf: got ovf=%b wen=%b want 0/0", overflow, imem_wen); end
    endtask

    task automatic test_saturate();
        do_reset(); imem_ready = 1;
        for (int i = 0; i < 2050; i++) begin
            pkt_in = mk(INSTR, ID, 16'(i), $urandom);
            @(negedge clk);
        end
        pkt_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (instr_count !== 11'h7FF) begin errors++; $display("FAIL saturate: got %h want 7ff", instr_count); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL saturate_model: got %h want %h", obs, expv); end
    endtask

    task automatic test_random();
        net_op_e op;
        logic [9:0] id;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++; if (obs !== expv) begin errors++; $display("FAIL rand_out@%0d: got %h want %h", i, obs, expv); end
            checks++; if (dut.state !== m_state) begin errors++; $display("FAIL rand_state@%0d: got %0d want %0d", i, dut.state, m_state); end
            checks++; if ($countones({imem_wen, rf_wen, bar_wen, pc_wen}) > 1)
                begin errors++; $display("FAIL rand_excl@%0d: got %b want onehot0", i, {imem_wen, rf_wen, bar_wen, pc_wen}); end
            reset = ($urandom_range(0, 149) != 0);
            imem_ready = ($urandom_range(0, 1) != 0);
            op = net_op_e'(3'($urandom_range(1, 7)));
            id = ($urandom_range(0, 4) == 0) ? 10'($urandom) : ID;
            if ($urandom_range(0, 3) == 0) pkt_in = '0;
            else pkt_in = mk(op, id, 16'($urandom), $urandom);
        end
        pkt_in = '0; reset = 1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_instr();
        test_reg_bar_pc();
        test_run_exit();
        test_overflow();
        test_reset_mid();
        test_filter();
        test_full_swap();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
